lstm_seq_ctrl: RTL and testbench

Input sequencer for the LSTM core. Accepts a word-serial input stream over a valid/ready handshake and assembles each timestep's `NUM`-word input vector in a shift register. For each timestep it drives the core's compute enable for a fixed window and marks the first timestep of a sequence on `o_sel`. It sits between the input memory/stream source and the LSTM core's `i_x` / `sel` inputs.

---
 rtl/lstm_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// LSTM input sequencer: assembles NUM-word timestep vectors and drives core enable.
// Optional LSTM_SEQ_FRAME_CHECK_EN flags a misplaced i_last as a sticky o_err.
module lstm_seq_ctrl #(
  parameter int NUM      = 35,
  parameter int WIDTH    = 32,
  parameter int CALC_CYC = 4,
  parameter int STEP_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [NUM*WIDTH-1:0]   o_x,
  output logic                   o_en,
  output logic                   o_sel,
  output logic [STEP_W-1:0]      o_step,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int WW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int CW = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(NUM - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CALC_CYC - 1);

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [WW-1:0]          wcnt;
  logic [CW-1:0]          ccnt;
  logic                   last_q;
  logic [STEP_W-1:0]      step_q;
  logic                   sel_q;
  logic [NUM*WIDTH-1:0]   x_q;
  logic                   accept;
  logic                   w_end;
  logic                   c_end;
  logic                   en_c;
  logic                   done_c;

  // Ready depends only on state and reset, so accept is loop-free.
  assign accept = i_valid && rst && (state == LOAD);
  assign w_end  = (wcnt == W_LAST);
  assign c_end  = (ccnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    en_c     = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      LOAD: begin
        if (accept && w_end) begin
          state_nx = CALC;
        end
      end
      CALC: begin
        en_c = 1'b1;
        if (c_end) begin
          state_nx = last_q ? DONE : LOAD;
        end
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt   <= '0;
      ccnt   <= '0;
      last_q <= 1'b0;
      step_q <= '0;
      sel_q  <= 1'b1;
      x_q    <= '0;
    end else begin
      if (accept) begin
        x_q  <= {i_data, x_q[NUM*WIDTH-1:WIDTH]};
        wcnt <= w_end ? '0 : wcnt + 1'b1;
        if (w_end) begin
          last_q <= i_last;
        end
      end
      if (state == CALC) begin
        ccnt <= c_end ? '0 : ccnt + 1'b1;
        if (c_end && !last_q && (step_q != '1)) begin
          step_q <= step_q + 1'b1;
          sel_q  <= 1'b0;
        end
      end
      if (state == DONE) begin
        step_q <= '0;
        sel_q  <= 1'b1;
        last_q <= 1'b0;
      end
    end
  end

`ifdef LSTM_SEQ_FRAME_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept && i_last && !w_end) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_ready = rst && (state == LOAD);
  assign o_en    = rst && en_c;
  assign o_done  = rst && done_c;
  assign o_x     = x_q;
  assign o_step  = step_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: randomized timesteps checked against a vector model.
// Define LSTM_SEQ_FRAME_CHECK_EN to expect the framing error behaviour.
module tb_lstm_seq_ctrl;

  localparam int NUM      = 35;
  localparam int WIDTH    = 32;
  localparam int CALC_CYC = 4;
  localparam int STEP_W   = 2;
  localparam int XW       = NUM * WIDTH;
  localparam int STEP_MAX = (1 << STEP_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic [WIDTH-1:0]   i_data;
  logic               i_last;
  logic               o_ready;
  logic [XW-1:0]      o_x;
  logic               o_en;
  logic               o_sel;
  logic [STEP_W-1:0]  o_step;
  logic               o_done;
  logic               o_err;

  int checks = 0;
  int errors = 0;
  int exp_step = 0;
  int exp_err = 0;
  logic [WIDTH-1:0] words [NUM];

  lstm_seq_ctrl #(
    .NUM      (NUM),
    .WIDTH    (WIDTH),
    .CALC_CYC (CALC_CYC),
    .STEP_W   (STEP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_x     (o_x),
    .o_en    (o_en),
    .o_sel   (o_sel),
    .o_step  (o_step),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XW-1:0] obs,
                     input logic [XW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset();
    chk("rst_x", o_x, XW'(0));
    chk("rst_step", XW'(o_step), XW'(0));
    chk("rst_sel", XW'(o_sel), XW'(1));
    chk("rst_err", XW'(o_err), XW'(0));
    chk("rst_en", XW'(o_en), XW'(0));
    chk("rst_done", XW'(o_done), XW'(0));
  endtask

  // One timestep, entered and left at a negedge in LOAD.
  task automatic run_step(input int gap_pct, input bit last,
                          input bit noise, input int bad_idx,
                          input bit seq_words);
    logic [XW-1:0] exp_x;
    exp_x = '0;
    for (int i = 0; i < NUM; i++) begin
      words[i] = seq_words ? WIDTH'(i + 1) : $urandom;
      exp_x[i*WIDTH +: WIDTH] = words[i];
    end
    for (int i = 0; i < NUM; i++) begin
      bit v;
      int tries;
      v = 1'b0;
      tries = 0;
      while (!v) begin
        v = (tries >= 20) || (int'($urandom_range(99)) >= gap_pct);
        i_valid = v;
        i_data  = v ? words[i] : $urandom;
        i_last  = v ? ((last && i == NUM - 1) || i == bad_idx)
                    : 1'($urandom_range(1));
        chk("ready_load", XW'(o_ready), XW'(1));
        @(negedge clk);
        tries++;
      end
      if (i == bad_idx) begin
`ifdef LSTM_SEQ_FRAME_CHECK_EN
        exp_err = 1;
`endif
      end
      chk("err_load", XW'(o_err), XW'(exp_err));
    end
    for (int c = 0; c < CALC_CYC; c++) begin
      i_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      i_data  = $urandom;
      i_last  = 1'($urandom_range(1));
      chk("en_calc", XW'(o_en), XW'(1));
      chk("ready_calc", XW'(o_ready), XW'(0));
      chk("done_calc", XW'(o_done), XW'(0));
      chk("step_calc", XW'(o_step), XW'(exp_step));
      chk("sel_calc", XW'(o_sel), XW'(exp_step == 0));
      chk("x_calc", o_x, exp_x);
      @(negedge clk);
    end
    if (last) begin
      chk("done_pulse", XW'(o_done), XW'(1));
      chk("en_done", XW'(o_en), XW'(0));
      chk("ready_done", XW'(o_ready), XW'(0));
      chk("x_done", o_x, exp_x);
      @(negedge clk);
      exp_step = 0;
    end else begin
      exp_step = (exp_step < STEP_MAX) ? exp_step + 1 : STEP_MAX;
    end
    chk("ready_back", XW'(o_ready), XW'(1));
    chk("en_off", XW'(o_en), XW'(0));
    chk("done_off", XW'(o_done), XW'(0));
    chk("step_next", XW'(o_step), XW'(exp_step));
    chk("sel_next", XW'(o_sel), XW'(exp_step == 0));
    chk("err_next", XW'(o_err), XW'(exp_err));
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    i_valid = 1'b1;
    i_data  = $urandom;
    i_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", XW'(o_ready), XW'(0));
      chk("rst_en_hold", XW'(o_en), XW'(0));
    end
    chk_idle_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    #1;
    chk("ready_release", XW'(o_ready), XW'(1));
    chk_idle_reset();

    // Single timestep with words 1..NUM.
    run_step(0, 1'b1, 1'b0, -1, 1'b1);
    chk("x_lo_1", XW'(o_x[WIDTH-1:0]), XW'(1));
    chk("x_hi_35", XW'(o_x[XW-1:XW-WIDTH]), XW'(NUM));

    // Three timesteps, no gaps.
    run_step(0, 1'b0, 1'b0, -1, 1'b0);
    run_step(0, 1'b0, 1'b0, -1, 1'b0);
    run_step(0, 1'b1, 1'b0, -1, 1'b0);

    // Bubbles in LOAD, valid during CALC/DONE.
    run_step(40, 1'b0, 1'b1, -1, 1'b0);
    run_step(40, 1'b1, 1'b1, -1, 1'b0);

    // Step counter saturation.
    for (int s = 0; s < STEP_MAX + 2; s++) begin
      run_step(20, 1'b0, 1'b1, -1, 1'b0);
    end
    run_step(20, 1'b1, 1'b1, -1, 1'b0);

    // Reset mid-stream, partial vector discarded.
    run_step(0, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      i_last  = 1'b0;
      chk("ready_partial", XW'(o_ready), XW'(1));
      @(negedge clk);
    end
    rst     = 1'b0;
    i_valid = 1'b1;
    @(negedge clk);
    chk("ready_midrst", XW'(o_ready), XW'(0));
    chk_idle_reset();
    rst      = 1'b1;
    i_valid  = 1'b0;
    exp_step = 0;
    exp_err  = 0;
    #1;
    run_step(0, 1'b1, 1'b0, -1, 1'b0);

    // Misplaced i_last on word 10: no sequence end, error if checking.
    run_step(0, 1'b0, 1'b0, 9, 1'b0);
    run_step(0, 1'b1, 1'b1, -1, 1'b0);
    chk("err_sticky", XW'(o_err), XW'(exp_err));
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", XW'(o_err), XW'(0));
    rst     = 1'b1;
    exp_err = 0;
    #1;
    run_step(10, 1'b1, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
